// File: rtl/bram_controller_pkg.sv
// Shared types and the address-legality rule for the AXI block-RAM controller.
package bram_controller_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_WAIT} rstate_e;

  // Word-aligned and inside [base, base + 4*size_words); 33-bit so the top bound cannot wrap.
  function automatic logic addr_is_legal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned size_words);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(size_words) << 2);
    return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// Single-clock block RAM: one byte-enabled write port, one synchronous read port, read-before-write.
module byte_enable_ram
  import bram_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [BE_W-1:0]          i_be,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Both updates are non-blocking, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_bram_controller.sv
// Memory-side stage behind the AXI slave port: write/read FSMs in front of a byte-writable RAM.
module axi_bram_controller
  import bram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS   = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        axi_ACLK,
  input  logic        axi_ARESETN,
  input  logic        write_request_i,
  input  logic [31:0] write_address_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_strobe_i,
  output logic        write_done_o,
  output logic        write_error_o,
  output logic        write_busy_o,
  output logic        write_ready_o,
  input  logic        read_request_i,
  input  logic [31:0] read_address_i,
  output logic [31:0] read_data_o,
  output logic        read_error_o,
  output logic        read_done_o,
  output logic        read_busy_o,
  output logic        read_ready_o
);

  localparam int unsigned IW = $clog2(SIZE_WORDS);
  localparam int unsigned CW = $clog2(READ_LATENCY + 1);

  wstate_e       r_wstate;
  logic          r_wdone;
  logic          r_werr;
  rstate_e       r_rstate;
  logic [CW-1:0] r_rcnt;
  logic          r_rdone;
  logic          r_rerr;
  logic          r_rlegal;

  logic          w_wlegal;
  logic          w_rlegal;
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_ridx;
  logic          w_wr_accept;
  logic          w_rd_accept;
  logic [31:0]   w_ram_q;

  assign w_wlegal    = addr_is_legal(write_address_i, BASE_ADDRESS, SIZE_WORDS);
  assign w_rlegal    = addr_is_legal(read_address_i, BASE_ADDRESS, SIZE_WORDS);
  assign w_widx      = IW'((write_address_i - BASE_ADDRESS) >> 2);
  assign w_ridx      = IW'((read_address_i - BASE_ADDRESS) >> 2);
  assign w_wr_accept = write_request_i && (r_wstate == W_IDLE);
  assign w_rd_accept = read_request_i && (r_rstate == R_IDLE);

  byte_enable_ram #(
    .DEPTH (SIZE_WORDS)
  ) u_ram (
    .clk     (axi_ACLK),
    .i_we    (w_wr_accept && w_wlegal),
    .i_waddr (w_widx),
    .i_wdata (write_data_i),
    .i_be    (write_strobe_i),
    .i_re    (w_rd_accept),
    .i_raddr (w_ridx),
    .o_rdata (w_ram_q)
  );

  // Write path: one response cycle after every accepted request.
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      r_wstate <= W_IDLE;
      r_wdone  <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (write_request_i) begin
            r_wstate <= W_RESP;
            r_wdone  <= 1'b1;
            r_werr   <= !w_wlegal;
          end
        end
        W_RESP: begin
          r_wstate <= W_IDLE;
          r_wdone  <= 1'b0;
          r_werr   <= 1'b0;
        end
        default: begin
          r_wstate <= W_IDLE;
          r_wdone  <= 1'b0;
          r_werr   <= 1'b0;
        end
      endcase
    end
  end

  // Read path: the counter stretches the RAM's one-cycle read out to READ_LATENCY.
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= '0;
      r_rdone  <= 1'b0;
      r_rerr   <= 1'b0;
      r_rlegal <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (read_request_i) begin
            r_rstate <= R_WAIT;
            r_rcnt   <= CW'(READ_LATENCY - 1);
            r_rdone  <= (READ_LATENCY == 1);
            r_rerr   <= !w_rlegal;
            r_rlegal <= w_rlegal;
          end
        end
        R_WAIT: begin
          if (r_rcnt == '0) begin
            r_rstate <= R_IDLE;
            r_rdone  <= 1'b0;
          end else begin
            r_rcnt  <= r_rcnt - CW'(1);
            r_rdone <= (r_rcnt == CW'(1));
          end
        end
        default: begin
          r_rstate <= R_IDLE;
          r_rdone  <= 1'b0;
        end
      endcase
    end
  end

  assign write_done_o  = r_wdone;
  assign write_error_o = r_werr;
  assign write_busy_o  = (r_wstate == W_RESP);
  assign write_ready_o = (r_wstate == W_IDLE) && !write_request_i;

  // RAM output only changes on an accepted read, so the masked word holds between reads.
  assign read_data_o   = r_rlegal ? w_ram_q : 32'h0;
  assign read_error_o  = r_rerr;
  assign read_done_o   = r_rdone;
  assign read_busy_o   = (r_rstate == R_WAIT);
  assign read_ready_o  = (r_rstate == R_IDLE) && !read_request_i;

`ifdef SV_ASSERTION
  a_wreq_ready: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
    write_request_i |-> (r_wstate == W_IDLE));
  a_rreq_ready: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
    read_request_i |-> (r_rstate == R_IDLE));
  a_wdone_busy: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
    write_done_o |-> write_busy_o);
  a_rdone_busy: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
    read_done_o |-> read_busy_o);
  a_wdone_pulse: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
    write_done_o |=> !write_done_o);
  a_rdone_pulse: assert property (@(posedge axi_ACLK) disable iff (!axi_ARESETN)
    read_done_o |=> !read_done_o);
`endif

endmodule

// File: tb/tb_axi_bram_controller.sv
// Self-checking bench for axi_bram_controller against a word-array reference model.
module tb_axi_bram_controller;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned SIZE = 256;
  localparam int unsigned RL   = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        w_req, w_done, w_err, w_busy, w_rdy;
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;
  logic        r_req, r_err, r_done, r_busy, r_rdy;
  logic [31:0] r_addr, r_data;

  logic        q_rst_n;
  logic        q_w_req, q_w_done, q_w_err, q_w_busy, q_w_rdy;
  logic [31:0] q_w_addr, q_w_data;
  logic [3:0]  q_w_strb;
  logic        q_r_req, q_r_err, q_r_done, q_r_busy, q_r_rdy;
  logic [31:0] q_r_addr, q_r_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [int];
  int          known_q[$];

  axi_bram_controller #(.BASE_ADDRESS(BASE), .SIZE_WORDS(SIZE), .READ_LATENCY(RL)) u_dut (
    .axi_ACLK(clk), .axi_ARESETN(rst_n),
    .write_request_i(w_req), .write_address_i(w_addr), .write_data_i(w_data),
    .write_strobe_i(w_strb), .write_done_o(w_done), .write_error_o(w_err),
    .write_busy_o(w_busy), .write_ready_o(w_rdy),
    .read_request_i(r_req), .read_address_i(r_addr), .read_data_o(r_data),
    .read_error_o(r_err), .read_done_o(r_done), .read_busy_o(r_busy), .read_ready_o(r_rdy)
  );

  axi_bram_controller #(.BASE_ADDRESS(32'h0), .SIZE_WORDS(1024), .READ_LATENCY(4)) u_dut4 (
    .axi_ACLK(clk), .axi_ARESETN(q_rst_n),
    .write_request_i(q_w_req), .write_address_i(q_w_addr), .write_data_i(q_w_data),
    .write_strobe_i(q_w_strb), .write_done_o(q_w_done), .write_error_o(q_w_err),
    .write_busy_o(q_w_busy), .write_ready_o(q_w_rdy),
    .read_request_i(q_r_req), .read_address_i(q_r_addr), .read_data_o(q_r_data),
    .read_error_o(q_r_err), .read_done_o(q_r_done), .read_busy_o(q_r_busy), .read_ready_o(q_r_rdy)
  );

  function automatic bit legal_m(input logic [31:0] a);
    return (a % 4 == 0) && (longint'(a) >= longint'(BASE)) &&
           (longint'(a) < longint'(BASE) + 4 * longint'(SIZE));
  endfunction

  function automatic int idx_m(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    int          i;
    if (!legal_m(a)) return;
    i = idx_m(a);
    if (!mem_m.exists(i) && s != 4'hF) return;
    if (!mem_m.exists(i)) begin
      mem_m[i] = 32'h0;
      known_q.push_back(i);
    end
    cur = mem_m[i];
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    mem_m[i] = cur;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return legal_m(a) ? mem_m[idx_m(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return BASE + 32'(4 * SIZE) + 32'(4 * $urandom_range(0, 15));
    if (k == 1) return BASE - 32'(4 * $urandom_range(1, 8));
    if (k == 2) return BASE + 32'(4 * $urandom_range(0, SIZE - 1)) + 32'($urandom_range(1, 3));
    return BASE + 32'(4 * $urandom_range(0, SIZE - 1));
  endfunction

  // Drives one write at the current cycle and waits (bounded) for its done pulse.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output int lat, output logic err);
    w_req = 1'b1; w_addr = a; w_data = d; w_strb = s;
    @(posedge clk); #1;
    w_req = 1'b0;
    lat = 0; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      if (w_done) begin lat = i; err = w_err; break; end
      @(posedge clk); #1;
    end
    model_write(a, d, s);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output int lat, output logic [31:0] d, output logic err);
    r_req = 1'b1; r_addr = a;
    @(posedge clk); #1;
    r_req = 1'b0;
    lat = 0; err = 1'bx; d = 'x;
    for (int i = 1; i <= 10; i++) begin
      if (r_done) begin lat = i; err = r_err; d = r_data; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (w_done !== 1'b0) begin failures++; $display("FAIL reset_wdone got=%b exp=0", w_done); end
    checks++; if (w_err !== 1'b0) begin failures++; $display("FAIL reset_werr got=%b exp=0", w_err); end
    checks++; if (w_busy !== 1'b0) begin failures++; $display("FAIL reset_wbusy got=%b exp=0", w_busy); end
    checks++; if (w_rdy !== 1'b1) begin failures++; $display("FAIL reset_wrdy got=%b exp=1", w_rdy); end
    checks++; if (r_done !== 1'b0) begin failures++; $display("FAIL reset_rdone got=%b exp=0", r_done); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL reset_rerr got=%b exp=0", r_err); end
    checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", r_data); end
    checks++; if (r_busy !== 1'b0) begin failures++; $display("FAIL reset_rbusy got=%b exp=0", r_busy); end
    checks++; if (r_rdy !== 1'b1) begin failures++; $display("FAIL reset_rrdy got=%b exp=1", r_rdy); end
  endtask

  task automatic test_basic();
    int lat; logic err; logic [31:0] d;
    wr(BASE + 32'h10, 32'hDEADBEEF, 4'hF, lat, err);
    checks++; if (lat !== 1) begin failures++; $display("FAIL basic_wlat got=%0d exp=1", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_werr got=%b exp=0", err); end
    rd(BASE + 32'h10, lat, d, err);
    checks++; if (lat !== int'(RL)) begin failures++; $display("FAIL basic_rlat got=%0d exp=%0d", lat, RL); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rdata got=%h exp=deadbeef", d); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_rerr got=%b exp=0", err); end
  endtask

  task automatic test_partial();
    int lat; logic err; logic [31:0] d;
    wr(BASE + 32'h20, 32'hFFFFFFFF, 4'hF, lat, err);
    wr(BASE + 32'h20, 32'h11223344, 4'b0101, lat, err);
    rd(BASE + 32'h20, lat, d, err);
    checks++; if (d !== 32'hFF22FF44) begin failures++; $display("FAIL partial_rdata got=%h exp=ff22ff44", d); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL partial_rerr got=%b exp=0", err); end
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] d;
    logic [31:0] bad [3];
    bad[0] = BASE + 32'h2; bad[1] = BASE + 32'(4 * SIZE); bad[2] = BASE - 32'h4;
    wr(BASE, 32'h12345678, 4'hF, lat, err);
    wr(BASE + 32'(4 * SIZE) - 32'h4, 32'hCAFEF00D, 4'hF, lat, err);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_lastword_werr got=%b exp=0", err); end
    for (int i = 0; i < 3; i++) begin
      wr(bad[i], 32'hFFFFFFFF, 4'hF, lat, err);
      checks++; if (lat !== 1 || err !== 1'b1) begin failures++; $display("FAIL err_wr%0d lat=%0d err=%b exp lat=1 err=1", i, lat, err); end
    end
    rd(BASE, lat, d, err);
    checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL err_unchanged0 got=%h exp=12345678", d); end
    rd(BASE + 32'(4 * SIZE) - 32'h4, lat, d, err);
    checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL err_lastword got=%h exp=cafef00d", d); end
    rd(BASE + 32'(4 * SIZE), lat, d, err);
    checks++; if (lat !== int'(RL) || d !== 32'h0 || err !== 1'b1) begin
      failures++; $display("FAIL err_rd_oor lat=%0d data=%h err=%b exp lat=%0d data=0 err=1", lat, d, err, RL); end
    rd(BASE + 32'h1, lat, d, err);
    checks++; if (d !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL err_rd_mis data=%h err=%b exp 0/1", d, err); end
  endtask

  task automatic test_rbw();
    int lat; logic err; logic [31:0] d; int rlat;
    wr(BASE + 32'h40, 32'hA5A5A5A5, 4'hF, lat, err);
    w_req = 1'b1; w_addr = BASE + 32'h40; w_data = 32'h5A5A5A5A; w_strb = 4'hF;
    r_req = 1'b1; r_addr = BASE + 32'h40;
    @(posedge clk); #1;
    w_req = 1'b0; r_req = 1'b0;
    checks++; if (w_done !== 1'b1) begin failures++; $display("FAIL rbw_wdone got=%b exp=1", w_done); end
    rlat = 0; d = 'x;
    for (int i = 1; i <= 10; i++) begin
      if (r_done) begin rlat = i; d = r_data; break; end
      @(posedge clk); #1;
    end
    model_write(BASE + 32'h40, 32'h5A5A5A5A, 4'hF);
    checks++; if (rlat !== int'(RL) || d !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL rbw_old lat=%0d data=%h exp lat=%0d data=a5a5a5a5", rlat, d, RL); end
    @(posedge clk); #1;
    rd(BASE + 32'h40, lat, d, err);
    checks++; if (d !== 32'h5A5A5A5A) begin failures++; $display("FAIL rbw_new got=%h exp=5a5a5a5a", d); end
  endtask

  task automatic test_ready_busy();
    r_req = 1'b1; r_addr = BASE + 32'h10;
    #1;
    checks++; if (r_rdy !== 1'b0) begin failures++; $display("FAIL rb_rrdy_T got=%b exp=0", r_rdy); end
    @(posedge clk); #1;
    r_req = 1'b0;
    for (int k = 1; k <= int'(RL); k++) begin
      checks++; if (r_rdy !== 1'b0 || r_busy !== 1'b1 || r_done !== (k == int'(RL))) begin
        failures++; $display("FAIL rb_T+%0d rdy=%b busy=%b done=%b", k, r_rdy, r_busy, r_done); end
      if (k == int'(RL)) begin
        checks++; if (r_data !== exp_rdata(BASE + 32'h10)) begin failures++; $display("FAIL rb_data got=%h exp=%h", r_data, exp_rdata(BASE + 32'h10)); end
      end
      @(posedge clk); #1;
    end
    checks++; if (r_rdy !== 1'b1 || r_busy !== 1'b0 || r_done !== 1'b0) begin
      failures++; $display("FAIL rb_after rdy=%b busy=%b done=%b exp 1/0/0", r_rdy, r_busy, r_done); end
    w_req = 1'b1; w_addr = BASE + 32'h80; w_data = 32'h0BADF00D; w_strb = 4'hF;
    #1;
    checks++; if (w_rdy !== 1'b0 || w_busy !== 1'b0) begin failures++; $display("FAIL wb_T rdy=%b busy=%b exp 0/0", w_rdy, w_busy); end
    @(posedge clk); #1;
    w_req = 1'b0;
    model_write(BASE + 32'h80, 32'h0BADF00D, 4'hF);
    checks++; if (w_rdy !== 1'b0 || w_busy !== 1'b1 || w_done !== 1'b1) begin
      failures++; $display("FAIL wb_T+1 rdy=%b busy=%b done=%b exp 0/1/1", w_rdy, w_busy, w_done); end
    @(posedge clk); #1;
    checks++; if (w_rdy !== 1'b1 || w_busy !== 1'b0 || w_done !== 1'b0) begin
      failures++; $display("FAIL wb_T+2 rdy=%b busy=%b done=%b exp 1/0/0", w_rdy, w_busy, w_done); end
  endtask

  task automatic test_back_to_back();
    r_req = 1'b1; r_addr = BASE + 32'h80;
    @(posedge clk); #1;
    r_req = 1'b0;
    @(posedge clk); #1;
    w_req = 1'b1; w_addr = BASE + 32'h84; w_data = 32'h01020304; w_strb = 4'hF;
    @(posedge clk); #1;
    w_req = 1'b0;
    model_write(BASE + 32'h84, 32'h01020304, 4'hF);
    checks++; if (w_done !== 1'b1 || r_done !== 1'b1 || r_data !== exp_rdata(BASE + 32'h80)) begin
      failures++; $display("FAIL b2b_both wdone=%b rdone=%b data=%h exp 1/1/%h", w_done, r_done, r_data, exp_rdata(BASE + 32'h80)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic err; logic [31:0] d, a, wd, ra; logic [3:0] s;
    for (int n = 0; n < 60; n++) begin
      a = rand_addr(); wd = $urandom(); s = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) s = 4'hF;
      wr(a, wd, s, lat, err);
      checks++; if (lat !== 1 || err !== !legal_m(a)) begin
        failures++; $display("FAIL rand_wr%0d addr=%h lat=%0d err=%b exp lat=1 err=%b", n, a, lat, err, !legal_m(a)); end
      if ($urandom_range(0, 4) == 0 || known_q.size() == 0) ra = rand_addr();
      else ra = BASE + 32'(4 * known_q[$urandom_range(0, known_q.size() - 1)]);
      if (legal_m(ra) && !mem_m.exists(idx_m(ra))) continue;
      rd(ra, lat, d, err);
      checks++; if (lat !== int'(RL) || d !== exp_rdata(ra) || err !== !legal_m(ra)) begin
        failures++; $display("FAIL rand_rd%0d addr=%h lat=%0d data=%h err=%b exp lat=%0d data=%h err=%b",
                             n, ra, lat, d, err, RL, exp_rdata(ra), !legal_m(ra)); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [31:0] d, v;
    v = $urandom();
    q_w_req = 1'b1; q_w_addr = 32'h40; q_w_data = v; q_w_strb = 4'hF;
    @(posedge clk); #1;
    q_w_req = 1'b0;
    @(posedge clk); #1;
    q_r_req = 1'b1; q_r_addr = 32'h40;
    @(posedge clk); #1;
    q_r_req = 1'b0; lat = 0; d = 'x;
    for (int i = 1; i <= 10; i++) begin
      if (q_r_done) begin lat = i; d = q_r_data; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 4 || d !== v) begin failures++; $display("FAIL rl4_read lat=%0d data=%h exp lat=4 data=%h", lat, d, v); end
    @(posedge clk); #1;
    q_r_req = 1'b1;
    @(posedge clk); #1;
    q_r_req = 1'b0;
    checks++; if (q_r_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", q_r_busy); end
    q_rst_n = 1'b0;
    #1;
    checks++; if (q_r_busy !== 1'b0 || q_r_rdy !== 1'b1 || q_r_done !== 1'b0 || q_r_data !== 32'h0 || q_r_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset busy=%b rdy=%b done=%b data=%h err=%b exp 0/1/0/0/0",
                           q_r_busy, q_r_rdy, q_r_done, q_r_data, q_r_err); end
    @(posedge clk); #1;
    q_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (q_r_done) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_done got=%0d pulses exp=0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; q_rst_n = 1'b0;
    w_req = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
    r_req = 1'b0; r_addr = '0;
    q_w_req = 1'b0; q_w_addr = '0; q_w_data = '0; q_w_strb = '0;
    q_r_req = 1'b0; q_r_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; q_rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_partial();
    test_errors();
    test_rbw();
    test_ready_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
